// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_TXSCHED_REQ
// byte producers. Each grant is sent as a header frame {tag, source} followed
// by the payload frame, with a per-frame timeout on the transmitter's done.
module tx_scheduler #(
    parameter int unsigned NB_TXSCHED_DATA = 8,
    parameter int unsigned NUM_TXSCHED_REQ = 4,
    parameter logic [NB_TXSCHED_DATA-$clog2(NUM_TXSCHED_REQ)-1:0] TXSCHED_HDR_TAG = 6'b101010,
    parameter int unsigned TXSCHED_TIMEOUT = 65535
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    input  logic [NUM_TXSCHED_REQ-1:0]                 i_txsched_REQ,
    input  logic [NUM_TXSCHED_REQ*NB_TXSCHED_DATA-1:0] i_txsched_DATA,
    output logic [NUM_TXSCHED_REQ-1:0]                 o_txsched_ACK,
    output logic                                       o_txsched_TXSTART,
    output logic [NB_TXSCHED_DATA-1:0]                 o_txsched_DIN,
    input  logic                                       i_txsched_TXDONE,
    output logic                                       o_txsched_BUSY,
    output logic                                       o_txsched_ERROR
);

    localparam int unsigned REQ_W = NUM_TXSCHED_REQ;
    localparam int unsigned PTR_W = $clog2(NUM_TXSCHED_REQ);
    localparam int unsigned CNT_W = $clog2(TXSCHED_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TXSCHED_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HDR  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t                     state_q;
    logic [PTR_W-1:0]           ptr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [NB_TXSCHED_DATA-1:0] payload_q;
    logic [REQ_W-1:0]           ack_q;
    logic                       txstart_q;
    logic [NB_TXSCHED_DATA-1:0] din_q;
    logic                       busy_q;
    logic                       error_q;

    logic                       grant_vld_c;
    logic [PTR_W-1:0]           grant_idx_c;
    logic [NB_TXSCHED_DATA-1:0] data_a [NUM_TXSCHED_REQ];

    // Unpack the flat payload bus into one byte per requester
    for (genvar g = 0; g < NUM_TXSCHED_REQ; g++) begin : g_unpack
        assign data_a[g] = i_txsched_DATA[g*NB_TXSCHED_DATA +: NB_TXSCHED_DATA];
    end

    // First asserted request scanning upward from the round-robin pointer
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        for (int unsigned i = 0; i < NUM_TXSCHED_REQ; i++) begin
            if (!grant_vld_c && i_txsched_REQ[ptr_q + PTR_W'(i)]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = ptr_q + PTR_W'(i);
            end
        end
    end

    // Scheduler FSM with registered pulses, byte and status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            payload_q <= '0;
            ack_q     <= '0;
            txstart_q <= 1'b0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            ack_q     <= '0;
            txstart_q <= 1'b0;
            error_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_c) begin
                        ack_q     <= REQ_W'(1) << grant_idx_c;
                        txstart_q <= 1'b1;
                        din_q     <= {TXSCHED_HDR_TAG, grant_idx_c};
                        payload_q <= data_a[grant_idx_c];
                        ptr_q     <= grant_idx_c + PTR_W'(1);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_WAIT_HDR;
                    end
                end
                ST_WAIT_HDR: begin
                    if (i_txsched_TXDONE) begin
                        txstart_q <= 1'b1;
                        din_q     <= payload_q;
                        cnt_q     <= '0;
                        state_q   <= ST_WAIT_DATA;
                    end else if (cnt_q == CNT_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_DATA: begin
                    if (i_txsched_TXDONE) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_txsched_ACK     = ack_q;
    assign o_txsched_TXSTART = txstart_q;
    assign o_txsched_DIN     = din_q;
    assign o_txsched_BUSY    = busy_q;
    assign o_txsched_ERROR   = error_q;

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Round-robin scheduler that shares the single UART transmitter between `NUM_REQ` byte producers. It sits between the requesters (ALU result path, debug/status sources) and the TX module. For each granted request it sequences two UART frames: a header byte identifying the source, then the payload byte. It drives the transmitter's start and data inputs and waits for the transmitter's done pulse between frames.

## Interface
Parameters:
- `NB_TXSCHED_DATA`, default 8: payload and UART byte width.
- `NUM_TXSCHED_REQ`, default 4: number of requesters; must be a power of 2, range 2..(2^(NB_TXSCHED_DATA-1)).
- `TXSCHED_HDR_TAG`, default 6'b101010: upper header bits; width is NB_TXSCHED_DATA - log2(NUM_TXSCHED_REQ).
- `TXSCHED_TIMEOUT`, default 65535: clock cycles allowed per frame before abort.

Ports:
- `i_clk` in 1: clock. Single clock domain.
- `i_reset` in 1: synchronous, active-high reset.
- `i_txsched_REQ` in NUM_TXSCHED_REQ: per-requester request level.
- `i_txsched_DATA` in NUM_TXSCHED_REQ*NB_TXSCHED_DATA: payloads. Requester k occupies bits [k*NB+NB-1 : k*NB].
- `o_txsched_ACK` out NUM_TXSCHED_REQ: one-hot, one-cycle pulse; payload of requester k has been captured.
- `o_txsched_TXSTART` out 1: one-cycle start pulse to the transmitter.
- `o_txsched_DIN` out NB_TXSCHED_DATA: byte presented to the transmitter. Held stable until the next start pulse.
- `i_txsched_TXDONE` in 1: one-cycle done pulse from the transmitter.
- `o_txsched_BUSY` out 1: high in every state except IDLE.
- `o_txsched_ERROR` out 1: one-cycle pulse on frame timeout.

## Operation
- All outputs are registered. Reset values: ACK=0, TXSTART=0, DIN=0, BUSY=0, ERROR=0. State=IDLE. Round-robin pointer=0, so requester 0 has highest priority first.
- Arbitration: in IDLE, pick the first asserted REQ scanning from pointer, pointer+1, … wrapping modulo NUM_TXSCHED_REQ. After a grant to k, pointer becomes (k+1) mod NUM_TXSCHED_REQ.
- Header byte: {TXSCHED_HDR_TAG, k}. With defaults: k=0→0xA8, 1→0xA9, 2→0xAA, 3→0xAB.
- States:
  - IDLE: if any REQ, then grant k, capture DATA[k], pulse ACK[k], pulse TXSTART with DIN=header, clear timeout counter, go to WAIT_HDR.
  - WAIT_HDR: on TXDONE, pulse TXSTART with DIN=captured payload, clear counter, go to WAIT_DATA.
  - WAIT_DATA: on TXDONE, go to IDLE.
  - In either WAIT state: counter increments each cycle without TXDONE. At counter==TXSCHED_TIMEOUT-1, pulse ERROR and go to IDLE. The payload is dropped and the pointer is not reverted.
- The payload is captured at grant. A requester may change DATA or drop REQ after its ACK. A requester that keeps REQ high is re-served only after the other pending requesters (fairness).
- REQ deasserting before grant is simply not served. There is no latching of requests.
- TXDONE in IDLE is ignored. TXDONE in the same cycle as the timeout limit counts as done, with no ERROR.
- Reset mid-operation: return to IDLE on the next edge with all outputs at reset values. The in-flight frame is abandoned. The transmitter has its own reset.

## Timing
- REQ sampled high at edge N in IDLE: ACK[k], TXSTART and DIN=header are visible after edge N, for one cycle. BUSY goes high in the same cycle.
- TXDONE sampled at edge M in WAIT_HDR: TXSTART with payload is visible after edge M.
- TXDONE sampled at edge P in WAIT_DATA: BUSY goes low after edge P. The earliest next grant is edge P+1, so there is one idle cycle between transactions.
- Only one TXSTART pulse per frame. There are never two TXSTART pulses without an intervening TXDONE or timeout.

## Test plan
- Single request: REQ=4'b0100, DATA[2]=0x5C, TX model returns TXDONE 10 cycles after each start. Required: ACK=4'b0100 once, DIN sequence 0xAA then 0x5C, BUSY falls after the second done.
- All requesting: REQ=4'b1111 held, payloads 0x10/0x11/0x12/0x13. Required: header/payload pairs in order 0xA8/0x10, 0xA9/0x11, 0xAA/0x12, 0xAB/0x13, then repeating from 0xA8.
- Fairness: REQ[0] held, REQ[3] asserted during requester 0's transaction. Required: next grant goes to 3 (0xAB), then back to 0.
- Timeout with TXSCHED_TIMEOUT=20 and TXDONE never returned. Required: ERROR pulses 20 cycles after the header start, the FSM is back in IDLE, no payload start.
- Data change after ACK: DATA[1] switches from 0x33 to 0xFF the cycle after ACK[1]. Required: transmitted payload is 0x33.
- Reset during WAIT_DATA: assert i_reset for 1 cycle. Required: all outputs 0 on the next cycle, pointer 0, a subsequent REQ=4'b1010 grants requester 1 first.
